norm_issue_fifo: RTL and testbench
==================================

Name: norm_issue_fifo

Overview:
Column-wise output FIFO between the MAC array's per-column psum outputs and the normalization stage. Each column writes its psum independently. A row is complete once all columns have written it. An issue FSM launches complete rows to the normalizer one at a time. Each launch is a single-cycle valid pulse (rising-edge detectable), and the FSM waits for the normalizer's divide-complete handshake before launching the next row.

Parameters:
bw, 8, activation bit width
bw_psum, 2*bw+4, per-column psum width (20)
col, 8, number of columns
depth, 16, rows per column FIFO (power of two)

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-high
wr  input  col  per-column write enable
in  input  bw_psum*col  column c psum on in[bw_psum*(c+1)-1:bw_psum*c]
norm_div_complete  input  1  normalizer idle/done flag (high = idle)
out  output  bw_psum*col  issued row, same packing as in; registered
out_valid  output  1  one-cycle issue pulse to normalizer
o_full  output  1  any column FIFO holds depth entries
o_ready  output  1  ~o_full
o_empty  output  1  no complete row available
overflow  output  1  sticky: write attempted to a full column
issue_cnt  output  8  rows issued since reset, wraps 255->0

Behaviour:
- Reset (sync, dominates everything): wr_ptr[c]=0, rd_ptr=0, state=IDLE, out=0, out_valid=0, overflow=0, issue_cnt=0. Reset mid-issue aborts the issue; FIFO contents are discarded logically.
- Pointers are log2(depth)+1 bits and wrap naturally.
- Column c full when wr_ptr[c]-rd_ptr==depth.
- Row available (row_avail) when wr_ptr[c]!=rd_ptr for every c.
- o_empty=~row_avail; o_full=OR of column fulls. All flags are combinational from registered pointers.
- Write: wr[c] && ~full[c] -> mem[c][wr_ptr[c]] <= column c of in; wr_ptr[c]++. wr[c] && full[c] -> write dropped, overflow<=1.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE: if row_avail && norm_div_complete -> out<=row at rd_ptr, rd_ptr++, out_valid<=1, issue_cnt++, go ISSUE.
- ISSUE: out_valid<=0, go WAIT_ACK. out_valid is high exactly one cycle and low the cycle before it, giving a clean rising edge.
- WAIT_ACK: wait for norm_div_complete==0, then go WAIT_DONE. If it stays high for 4 cycles, go IDLE anyway (normalizer missed the pulse); the row is not re-issued.
- WAIT_DONE: when norm_div_complete==1, go IDLE.
- Minimum spacing between pulses is 4 cycles.
- out holds its value from load until the next load.
- Latency: the last column write to a row at edge N, with IDLE and div_complete high, gives out/out_valid visible after edge N+1.
- Same-cycle write and issue: legal. The rd_ptr increment frees a slot only from the next cycle, so full is evaluated on pre-edge pointers.
- Writes to an empty FIFO are never bypassed combinationally; data always goes through mem.
- Column skew: early columns may run up to depth rows ahead of late columns.

Test Plan:
- Reset, then all wr=8'hFF for one cycle with in = columns 1..8; div_complete=1 -> out_valid pulses one cycle after the write edge, out = {8,7,...,1}, issue_cnt=1, o_empty=1.
- Write 3 rows; hold div_complete=1 except driving it low 1 cycle after each pulse for 10 cycles -> 3 pulses, each ≥12 cycles apart, rows out in FIFO order.
- Column skew: column 0 writes 5 rows, then columns 1-7 write 5 rows -> no pulse until column 7's first write, then 5 ordered issues.
- Fill column 3 with 16 entries and no reads (div_complete=0) -> o_full=1, o_ready=0. 17th write is dropped, overflow=1 and stays 1. Pointer wrap past 16 works after drain.
- div_complete never drops after a pulse -> FSM returns to IDLE after 4 cycles and issues the next row; no row duplicated.
- Assert reset while in WAIT_DONE with 2 rows queued -> next cycle out=0, out_valid=0, o_empty=1, issue_cnt=0, and a fresh write issues normally.

Source files
------------

// File: rtl/norm_issue_fifo_if.sv
// rtl/norm_issue_fifo_if.sv - write/issue bundle between MAC columns, issue FIFO and normalizer
// master: column writers + normalizer side (drives wr, in, norm_div_complete)
// slave : norm_issue_fifo (drives out, out_valid, o_full, o_ready, o_empty, overflow, issue_cnt)
interface norm_issue_fifo_if #(
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int col     = 8
);
  logic [col-1:0]         wr;
  logic [bw_psum*col-1:0] in;
  logic                   norm_div_complete;
  logic [bw_psum*col-1:0] out;
  logic                   out_valid;
  logic                   o_full;
  logic                   o_ready;
  logic                   o_empty;
  logic                   overflow;
  logic [7:0]             issue_cnt;

  modport master (
    output wr, in, norm_div_complete,
    input  out, out_valid, o_full, o_ready, o_empty, overflow, issue_cnt
  );

  modport slave (
    input  wr, in, norm_div_complete,
    output out, out_valid, o_full, o_ready, o_empty, overflow, issue_cnt
  );
endinterface

// File: rtl/norm_issue_fifo.sv
// rtl/norm_issue_fifo.sv - column-wise psum FIFO with row issue FSM toward the normalizer
// clk   : clock, all logic on posedge
// reset : synchronous, active-high
// bus   : norm_issue_fifo_if.slave
//   wr/in             per-column psum writes (column c on in[bw_psum*c +: bw_psum])
//   norm_div_complete normalizer idle/done flag (high = idle)
//   out/out_valid     registered issued row and one-cycle issue pulse
//   o_full/o_ready/o_empty/overflow/issue_cnt  status
module norm_issue_fifo #(
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int col     = 8,
  parameter int depth   = 16
) (
  input logic         clk,
  input logic         reset,
  norm_issue_fifo_if.slave bus
);

  // One extra pointer bit distinguishes full from empty.
  localparam int pw = $clog2(depth) + 1;
  localparam logic [pw-1:0] depth_p = pw'(depth);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  logic [bw_psum-1:0]     mem [col][depth];
  logic [pw-1:0]          wr_ptr [col];
  logic [pw-1:0]          rd_ptr;
  logic [col-1:0]         full;
  logic [col-1:0]         nonempty;
  logic                   row_avail;
  logic [bw_psum*col-1:0] row_data;

  state_t                 state;
  logic [1:0]             ack_timer;
  logic [bw_psum*col-1:0] out_r;
  logic                   out_valid_r;
  logic                   overflow_r;
  logic [7:0]             issue_cnt_r;

  // Flags come only from registered pointers, so a same-cycle issue frees
  // a slot no earlier than the following cycle.
  always_comb begin
    full     = '0;
    nonempty = '0;
    row_data = '0;
    for (int c = 0; c < col; c++) begin
      full[c]     = (wr_ptr[c] - rd_ptr) == depth_p;
      nonempty[c] = wr_ptr[c] != rd_ptr;
      row_data[bw_psum*c +: bw_psum] = mem[c][rd_ptr[pw-2:0]];
    end
  end

  assign row_avail = &nonempty;

  // Storage has no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    for (int c = 0; c < col; c++) begin
      if (!reset && bus.wr[c] && !full[c]) begin
        mem[c][wr_ptr[c][pw-2:0]] <= bus.in[bw_psum*c +: bw_psum];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < col; c++) wr_ptr[c] <= '0;
      overflow_r <= 1'b0;
    end else begin
      for (int c = 0; c < col; c++) begin
        if (bus.wr[c]) begin
          if (full[c]) overflow_r <= 1'b1;
          else         wr_ptr[c] <= wr_ptr[c] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      out_r       <= '0;
      out_valid_r <= 1'b0;
      issue_cnt_r <= '0;
      ack_timer   <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_valid_r <= 1'b0;
          if (row_avail && bus.norm_div_complete) begin
            out_r       <= row_data;
            rd_ptr      <= rd_ptr + 1'b1;
            out_valid_r <= 1'b1;
            issue_cnt_r <= issue_cnt_r + 8'd1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          out_valid_r <= 1'b0;
          ack_timer   <= '0;
          state       <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // A normalizer that never drops its idle flag missed the pulse;
          // give up after four cycles rather than stall forever.
          if (!bus.norm_div_complete)  state <= WAIT_DONE;
          else if (ack_timer == 2'd3)  state <= IDLE;
          else                         ack_timer <= ack_timer + 2'd1;
        end
        WAIT_DONE: begin
          if (bus.norm_div_complete) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out       = out_r;
  assign bus.out_valid = out_valid_r;
  assign bus.o_full    = |full;
  assign bus.o_ready   = ~(|full);
  assign bus.o_empty   = ~row_avail;
  assign bus.overflow  = overflow_r;
  assign bus.issue_cnt = issue_cnt_r;

endmodule

// File: tb/tb_norm_issue_fifo.sv
// tb/tb_norm_issue_fifo.sv - scoreboard bench for norm_issue_fifo
module tb_norm_issue_fifo;
  localparam int bw      = 8;
  localparam int bw_psum = 2*bw+4;
  localparam int col     = 8;
  localparam int depth   = 16;
  localparam int rw      = bw_psum*col;

  typedef logic [rw-1:0] row_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  norm_issue_fifo_if #(.bw(bw), .bw_psum(bw_psum), .col(col)) bus();

  norm_issue_fifo #(.bw(bw), .bw_psum(bw_psum), .col(col), .depth(depth)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: per-column queues; a row is formed once every column holds one.
  logic [bw_psum-1:0] colq [col][$];
  int                 wcnt [col];
  row_t               exp_q [$];
  bit                 exp_overflow;

  // Monitor-owned state
  int   n_issued = 0;
  int   cyc = 0;
  int   last_pulse = 0;
  bit   have_pulse = 0;
  bit   prev_valid = 0;
  row_t last_row = '0;
  int   min_gap = 4;

  // Normalizer emulation: 0 = busy (low), 1 = handshake, 2 = never drops
  int resp_mode = 2;
  int lag = 1;
  int low_len = 2;
  bit rand_resp = 0;

  task automatic check(input string name, input logic [rw-1:0] act, input logic [rw-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [col-1:0] w, input row_t d);
    row_t r;
    bit all;
    for (int c = 0; c < col; c++) begin
      if (w[c]) begin
        if (wcnt[c] - n_issued >= depth) exp_overflow = 1;
        else begin
          colq[c].push_back(d[bw_psum*c +: bw_psum]);
          wcnt[c]++;
        end
      end
    end
    forever begin
      all = 1;
      for (int c = 0; c < col; c++) if (colq[c].size() == 0) all = 0;
      if (!all) break;
      for (int c = 0; c < col; c++) r[bw_psum*c +: bw_psum] = colq[c].pop_front();
      exp_q.push_back(r);
    end
  endtask

  // Called at posedge+1; the write lands on the next edge.
  task automatic drive_cycle(input logic [col-1:0] w, input row_t d);
    bus.wr = w;
    bus.in = d;
    model_write(w, d);
    step();
    bus.wr = '0;
  endtask

  function automatic row_t rand_row();
    row_t d;
    for (int c = 0; c < col; c++) d[bw_psum*c +: bw_psum] = bw_psum'($urandom);
    return d;
  endfunction

  // Writes n rows to the masked columns, never offering a write the model
  // might consider full (the monitor's issue count can lag by one edge).
  task automatic write_rows(input int n, input logic [col-1:0] mask);
    int done = 0;
    int guard = 0;
    bit ok;
    while (done < n && guard < 5000) begin
      guard++;
      ok = 1;
      for (int c = 0; c < col; c++) if (mask[c] && (wcnt[c] - n_issued >= depth)) ok = 0;
      if (ok) begin
        drive_cycle(mask, rand_row());
        done++;
      end else step();
    end
    check("write_budget", row_t'(done), row_t'(n));
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check("drain", row_t'(exp_q.size()), '0);
    repeat (40) step();
  endtask

  task automatic do_reset();
    bus.wr = '0;
    reset  = 1;
    for (int c = 0; c < col; c++) begin
      colq[c].delete();
      wcnt[c] = 0;
    end
    exp_overflow = 0;
    step();
    reset = 0;
  endtask

  // Monitor / scoreboard
  initial begin
    row_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        exp_q.delete();
        n_issued   = 0;
        have_pulse = 0;
        prev_valid = 0;
        last_row   = '0;
      end else begin
        if (bus.out_valid) begin
          check("pulse_rise", row_t'(prev_valid), '0);
          if (have_pulse) check("pulse_gap", row_t'((cyc - last_pulse) >= min_gap), row_t'(1));
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_issue: got %h want no pulse", bus.out);
          end else begin
            e = exp_q.pop_front();
            check("row", bus.out, e);
            last_row = e;
          end
          n_issued++;
          check("issue_cnt", row_t'(bus.issue_cnt), row_t'(n_issued[7:0]));
          last_pulse = cyc;
          have_pulse = 1;
        end else begin
          check("out_hold", bus.out, last_row);
        end
        prev_valid = bus.out_valid;
      end
    end
  end

  // Normalizer responder
  initial begin
    int l, ll;
    bus.norm_div_complete = 1'b1;
    forever begin
      @(negedge clk);
      if (resp_mode == 0) bus.norm_div_complete = 1'b0;
      else if (resp_mode == 2) bus.norm_div_complete = 1'b1;
      else begin
        bus.norm_div_complete = 1'b1;
        if (bus.out_valid && !reset) begin
          l  = rand_resp ? $urandom_range(0, 3) : lag;
          ll = rand_resp ? $urandom_range(1, 6) : low_len;
          repeat (l) @(negedge clk);
          bus.norm_div_complete = 1'b0;
          repeat (ll) @(negedge clk);
          bus.norm_div_complete = 1'b1;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t d;
    logic [col-1:0] w;
    bus.wr = '0;
    bus.in = '0;
    reset  = 1;
    exp_overflow = 0;
    for (int c = 0; c < col; c++) wcnt[c] = 0;
    repeat (3) step();
    do_reset();

    // Reset state and single-row latency
    check("rst_out", bus.out, '0);
    check("rst_valid", row_t'(bus.out_valid), '0);
    check("rst_empty", row_t'(bus.o_empty), row_t'(1));
    check("rst_full", row_t'(bus.o_full), '0);
    check("rst_ready", row_t'(bus.o_ready), row_t'(1));
    check("rst_ovf", row_t'(bus.overflow), '0);
    check("rst_cnt", row_t'(bus.issue_cnt), '0);
    for (int c = 0; c < col; c++) d[bw_psum*c +: bw_psum] = bw_psum'(c + 1);
    drive_cycle('1, d);
    check("lat_early", row_t'(bus.out_valid), '0);
    step();
    check("lat_valid", row_t'(bus.out_valid), row_t'(1));
    check("lat_out", bus.out, d);
    check("lat_cnt", row_t'(bus.issue_cnt), row_t'(1));
    check("lat_empty", row_t'(bus.o_empty), row_t'(1));
    step();
    check("lat_pulse_end", row_t'(bus.out_valid), '0);
    wait_drain(200);

    // Three rows with a slow normalizer handshake
    resp_mode = 1; lag = 1; low_len = 10; min_gap = 12;
    write_rows(3, '1);
    wait_drain(300);
    min_gap = 4;

    // Column skew: column 0 runs five rows ahead
    low_len = 2;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(8'h01, rand_row());
      check("skew_novalid", row_t'(bus.out_valid), '0);
      check("skew_empty", row_t'(bus.o_empty), row_t'(1));
    end
    drive_cycle(8'hFE, rand_row());
    drive_cycle(8'hFE, rand_row());
    check("skew_first", row_t'(bus.out_valid), row_t'(1));
    for (int i = 0; i < 3; i++) drive_cycle(8'hFE, rand_row());
    wait_drain(300);

    // Normalizer never acknowledges: timeout, no duplicates
    resp_mode = 2;
    write_rows(4, '1);
    wait_drain(300);

    // Overflow on column 3, then drain and wrap the pointers
    resp_mode = 0;
    do_reset();
    for (int i = 0; i < depth; i++) drive_cycle(8'h08, rand_row());
    check("full", row_t'(bus.o_full), row_t'(1));
    check("ready", row_t'(bus.o_ready), '0);
    check("ovf_pre", row_t'(bus.overflow), '0);
    drive_cycle(8'h08, rand_row());
    check("ovf_set", row_t'(bus.overflow), row_t'(exp_overflow));
    for (int i = 0; i < depth; i++) drive_cycle(8'hF7, rand_row());
    check("ovf_sticky", row_t'(bus.overflow), row_t'(1));
    check("empty_blocked", row_t'(bus.o_empty), '0);
    resp_mode = 1; lag = 0; low_len = 1;
    wait_drain(600);
    check("drained_full", row_t'(bus.o_full), '0);
    check("drained_empty", row_t'(bus.o_empty), row_t'(1));
    write_rows(24, '1);
    wait_drain(600);
    check("wrap_ovf", row_t'(bus.overflow), row_t'(1));

    // Reset in WAIT_DONE with two rows still queued
    do_reset();
    lag = 1; low_len = 30;
    write_rows(3, '1);
    for (int i = 0; i < 100 && n_issued < 1; i++) step();
    check("first_issue", row_t'(n_issued), row_t'(1));
    repeat (5) step();
    bus.wr = '0;
    reset  = 1;
    for (int c = 0; c < col; c++) begin
      colq[c].delete();
      wcnt[c] = 0;
    end
    exp_overflow = 0;
    step();
    check("mid_out", bus.out, '0);
    check("mid_valid", row_t'(bus.out_valid), '0);
    check("mid_empty", row_t'(bus.o_empty), row_t'(1));
    check("mid_cnt", row_t'(bus.issue_cnt), '0);
    reset = 0;
    low_len = 2;
    write_rows(1, '1);
    wait_drain(300);
    check("post_rst_cnt", row_t'(bus.issue_cnt), row_t'(1));

    // Randomized stress, long enough to wrap issue_cnt
    do_reset();
    rand_resp = 1;
    for (int guard = 0; guard < 40000; guard++) begin
      bit busy = 0;
      for (int c = 0; c < col; c++) begin
        w[c] = ($urandom_range(0, 1) == 1) && (wcnt[c] < 300) && (wcnt[c] - n_issued < depth);
        if (wcnt[c] < 300) busy = 1;
      end
      if (!busy) break;
      drive_cycle(w, rand_row());
    end
    wait_drain(5000);
    check("rand_ovf", row_t'(bus.overflow), '0);
    check("rand_empty", row_t'(bus.o_empty), row_t'(1));
    check("rand_cnt_wrap", row_t'(bus.issue_cnt), row_t'(8'd44));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
